// File: rtl/mv_pkg.sv
// mv_pkg: shared screen geometry, coordinate/colour widths and blitter state encoding
package mv_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 3;
  typedef enum logic [2:0] {IDLE, ERASE, DRAW, CLEAR, FINISH} state_t;
endpackage

// File: rtl/pixel_scanner.sv
// pixel_scanner: row-major col/row counter; load restarts at (0,0), en steps, col_nx/row_nx give the next position, last flags (w_last,h_last)
module pixel_scanner #(
  parameter int CW = 9,
  parameter int RW = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] w_last,
  input  logic [RW-1:0] h_last,
  output logic [CW-1:0] col_nx,
  output logic [RW-1:0] row_nx,
  output logic          last
);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          wrap;
  always_comb begin
    wrap = col == w_last;
    last = wrap && row == h_last;
    col_nx = load ? '0 : en ? (wrap ? '0 : col + 1'b1) : col;
    row_nx = load ? '0 : (en && wrap) ? row + 1'b1 : row;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nx;
      row <= row_nx;
    end
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: erase-old/draw-new sprite and full-screen clear pixel streamer; start/clear in, plot/x/y/colour pixel strobe out, busy/done status
module sprite_blitter import mv_pkg::*; #(
  parameter int SIZE     = 4,
  parameter int SCREEN_W = mv_pkg::SCREEN_W,
  parameter int SCREEN_H = mv_pkg::SCREEN_H
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           start,
  input  logic           clear,
  input  logic [X_W-1:0] old_x,
  input  logic [Y_W-1:0] old_y,
  input  logic [X_W-1:0] new_x,
  input  logic [Y_W-1:0] new_y,
  input  logic [C_W-1:0] sprite_colour,
  input  logic [C_W-1:0] bg_colour,
  output logic           plot,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           busy,
  output logic           done
);
  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);
  state_t         state, state_n;
  logic [X_W-1:0] ox, nx, a_ox, a_nx, bx, col_nx;
  logic [Y_W-1:0] oy, ny, a_oy, a_ny, by, row_nx;
  logic [C_W-1:0] sc, bc, a_sc, a_bc, pc_n;
  logic [X_W:0]   px_n;
  logic [Y_W:0]   py_n;
  logic           go, load, en, last, plot_n;
  always_comb begin
    go = state == IDLE && (start || clear);
    a_ox = go ? old_x : ox;
    a_oy = go ? old_y : oy;
    a_nx = go ? new_x : nx;
    a_ny = go ? new_y : ny;
    a_sc = go ? sprite_colour : sc;
    a_bc = go ? bg_colour : bc;
    busy = state != IDLE;
    done = state == FINISH;
    state_n = state;
    load = 1'b0;
    en = 1'b0;
    case (state)
      IDLE: begin
        state_n = clear ? CLEAR : start ? ERASE : IDLE;
        load = go;
      end
      ERASE: begin
        state_n = last ? DRAW : ERASE;
        load = last;
        en = !last;
      end
      DRAW, CLEAR: begin
        state_n = last ? FINISH : state;
        en = !last;
      end
      default: state_n = IDLE;
    endcase
  end
  pixel_scanner #(.CW(X_W), .RW(Y_W)) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .load   (load),
    .en     (en),
    .w_last (state == CLEAR ? X_W'(SCREEN_W - 1) : X_W'(SIZE - 1)),
    .h_last (state == CLEAR ? Y_W'(SCREEN_H - 1) : Y_W'(SIZE - 1)),
    .col_nx (col_nx),
    .row_nx (row_nx),
    .last   (last)
  );
  always_comb begin
    bx = state_n == ERASE ? a_ox : state_n == DRAW ? a_nx : '0;
    by = state_n == ERASE ? a_oy : state_n == DRAW ? a_ny : '0;
    pc_n = state_n == DRAW ? a_sc : a_bc;
    px_n = {1'b0, bx} + {1'b0, col_nx};
    py_n = {1'b0, by} + {1'b0, row_nx};
    plot_n = (state_n == ERASE || state_n == DRAW || state_n == CLEAR) && px_n < X_LIM && py_n < Y_LIM;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      plot <= 1'b0;
      x <= '0;
      y <= '0;
      colour <= '0;
      ox <= '0;
      oy <= '0;
      nx <= '0;
      ny <= '0;
      sc <= '0;
      bc <= '0;
    end else begin
      state <= state_n;
      plot <= plot_n;
      if (plot_n) begin
        x <= px_n[X_W-1:0];
        y <= py_n[Y_W-1:0];
        colour <= pc_n;
      end
      ox <= a_ox;
      oy <= a_oy;
      nx <= a_nx;
      ny <= a_ny;
      sc <= a_sc;
      bc <= a_bc;
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized self-checking bench with a pixel-list reference model and frame-buffer scoreboard
module tb_sprite_blitter;
  localparam int SIZE = 4;
  localparam int SW = 320;
  localparam int SH = 240;
  logic       clock = 1'b0;
  logic       resetn, start, clear;
  logic [8:0] old_x, new_x, x;
  logic [7:0] old_y, new_y, y;
  logic [2:0] sprite_colour, bg_colour, colour;
  logic       plot, busy, done;
  int         total = 0;
  int         bad = 0;
  int         busy_bad = 0;
  logic [2:0] fb_model [SW*SH];
  logic [2:0] fb_dut [SW*SH];
  logic [8:0] hx;
  logic [7:0] hy;
  logic [2:0] hc;

  sprite_blitter #(.SIZE(SIZE), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clock(clock), .resetn(resetn), .start(start), .clear(clear),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
    .sprite_colour(sprite_colour), .bg_colour(bg_colour),
    .plot(plot), .x(x), .y(y), .colour(colour), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (plot === 1'b1) begin
      if (busy !== 1'b1) busy_bad++;
      if (x < SW && y < SH) fb_dut[int'(y) * SW + int'(x)] = colour;
    end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic sprite_op(input int ox, input int oy, input int nx, input int ny,
                           input logic [2:0] sc, input logic [2:0] bc, input bit poke);
    int n, ex, ey, idx;
    logic [2:0] ec;
    logic ep;
    n = SIZE * SIZE;
    old_x = 9'(ox); old_y = 8'(oy); new_x = 9'(nx); new_y = 8'(ny);
    sprite_colour = sc; bg_colour = bc; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    old_x = 9'($urandom); old_y = 8'($urandom); new_x = 9'($urandom); new_y = 8'($urandom);
    sprite_colour = 3'($urandom); bg_colour = 3'($urandom);
    for (int k = 0; k < 2 * n; k++) begin
      idx = k % n;
      ex = (k < n ? ox : nx) + idx % SIZE;
      ey = (k < n ? oy : ny) + idx / SIZE;
      ec = k < n ? bc : sc;
      ep = ex < SW && ey < SH;
      if (ep) begin
        fb_model[ey * SW + ex] = ec;
        hx = 9'(ex); hy = 8'(ey); hc = ec;
      end
      total++;
      if (plot !== ep || x !== hx || y !== hy || colour !== hc || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL op_cycle%0d: got plot=%b x=%0d y=%0d colour=%0d busy=%b done=%b, want plot=%b x=%0d y=%0d colour=%0d busy=1 done=0",
                 k, plot, x, y, colour, busy, done, ep, hx, hy, hc);
      end
      if (poke && k == n + 2) begin start = 1'b1; new_x = 9'($urandom); end
      if (poke && k == n + 6) start = 1'b0;
      @(negedge clock);
    end
    total++;
    if (plot !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || x !== hx || y !== hy || colour !== hc) begin
      bad++;
      $display("FAIL op_finish: got plot=%b done=%b busy=%b x=%0d y=%0d c=%0d, want plot=0 done=1 busy=1 x=%0d y=%0d c=%0d",
               plot, done, busy, x, y, colour, hx, hy, hc);
    end
    @(negedge clock);
    total++;
    if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL op_idle: got plot=%b done=%b busy=%b, want 0 0 0", plot, done, busy);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; clear = 1'b0;
    old_x = '0; old_y = '0; new_x = '0; new_y = '0; sprite_colour = '0; bg_colour = '0;
    hx = '0; hy = '0; hc = '0;
    for (int i = 0; i < SW * SH; i++) begin fb_model[i] = '0; fb_dut[i] = '0; end
    #12;
    total++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_status: got plot=%b busy=%b done=%b, want 0 0 0", plot, busy, done);
    end
    total++;
    if (x !== 9'd0 || y !== 8'd0 || colour !== 3'd0) begin
      bad++;
      $display("FAIL reset_pixel: got x=%0d y=%0d colour=%0d, want 0 0 0", x, y, colour);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_basic;
    sprite_op(10, 20, 11, 20, 3'd5, 3'd2, 1'b0);
  endtask

  task automatic test_clip;
    sprite_op(100, 100, 318, 238, 3'd7, 3'd1, 1'b0);
    sprite_op(318, 238, 500, 250, 3'd4, 3'd3, 1'b0);
  endtask

  task automatic test_busy_ignore;
    sprite_op(40, 50, 42, 53, 3'd6, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (busy !== 1'b0 || plot !== 1'b0) begin
        bad++;
        $display("FAIL no_requeue%0d: got busy=%b plot=%b, want 0 0", i, busy, plot);
      end
    end
  endtask

  task automatic test_reset_mid;
    old_x = 9'd50; old_y = 8'd60; new_x = 9'd70; new_y = 8'd80;
    sprite_colour = 3'd3; bg_colour = 3'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      fb_model[(60 + k / SIZE) * SW + 50 + k % SIZE] = 3'd5;
      total++;
      if (plot !== 1'b1 || x !== 9'(50 + k % SIZE) || y !== 8'(60 + k / SIZE)) begin
        bad++;
        $display("FAIL abort_pixel%0d: got plot=%b x=%0d y=%0d, want 1 %0d %0d", k, plot, x, y, 50 + k % SIZE, 60 + k / SIZE);
      end
      if (k < 5) @(negedge clock);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || x !== 9'd0) begin
      bad++;
      $display("FAIL async_reset: got plot=%b busy=%b done=%b x=%0d, want 0 0 0 0", plot, busy, done, x);
    end
    hx = '0; hy = '0; hc = '0;
    @(negedge clock);
    resetn = 1'b1;
    sprite_op(200, 150, 203, 151, 3'd2, 3'd7, 1'b0);
  endtask

  task automatic test_clear;
    int errs, plots;
    logic [2:0] bgc;
    bgc = 3'd6; errs = 0; plots = 0;
    bg_colour = bgc; sprite_colour = 3'd1; clear = 1'b1; start = 1'b1;
    @(negedge clock);
    clear = 1'b0; start = 1'b0; bg_colour = 3'd2;
    for (int k = 0; k < SW * SH; k++) begin
      fb_model[k] = bgc;
      if (plot === 1'b1) plots++;
      if (plot !== 1'b1 || x !== 9'(k % SW) || y !== 8'(k / SW) || colour !== bgc || busy !== 1'b1 || done !== 1'b0) begin
        if (errs == 0) $display("clear first deviation at pixel %0d: x=%0d y=%0d colour=%0d plot=%b", k, x, y, colour, plot);
        errs++;
      end
      @(negedge clock);
    end
    hx = 9'(SW - 1); hy = 8'(SH - 1); hc = bgc;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL clear_scan: got %0d deviating cycles, want 0", errs);
    end
    total++;
    if (plots != SW * SH) begin
      bad++;
      $display("FAIL clear_plots: got %0d plots, want %0d", plots, SW * SH);
    end
    total++;
    if (done !== 1'b1 || plot !== 1'b0 || x !== hx || y !== hy) begin
      bad++;
      $display("FAIL clear_done: got done=%b plot=%b x=%0d y=%0d, want 1 0 %0d %0d", done, plot, x, y, hx, hy);
    end
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL clear_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int mm;
    for (int i = 0; i < 250; i++)
      sprite_op($urandom_range(0, 330), $urandom_range(0, 250), $urandom_range(0, 330), $urandom_range(0, 250),
                3'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0));
    mm = 0;
    for (int i = 0; i < SW * SH; i++) if (fb_dut[i] !== fb_model[i]) mm++;
    total++;
    if (mm != 0) begin
      bad++;
      $display("FAIL frame_buffer: got %0d differing pixels, want 0", mm);
    end
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL busy_with_plot: got %0d plots while idle, want 0", busy_bad);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_clip;
    test_busy_ignore;
    test_reset_mid;
    test_clear;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
